// File: rtl/coef_bank_dbuf_if.sv
// Load, swap and read bundle for the double-buffered coefficient bank.
interface coef_bank_dbuf_if #(
  parameter int COEF_W = 12,
  parameter int ADDR_W = 5
);
  logic              load_start;
  logic              load_valid;
  logic [COEF_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              swap_req;
  logic              swap_ack;
  logic              swap_err;
  logic              active_bank;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [COEF_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output load_start,
    output load_valid,
    output load_data,
    output swap_req,
    output rd_en,
    output rd_addr,
    input  load_ready,
    input  load_done,
    input  swap_ack,
    input  swap_err,
    input  active_bank,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  load_start,
    input  load_valid,
    input  load_data,
    input  swap_req,
    input  rd_en,
    input  rd_addr,
    output load_ready,
    output load_done,
    output swap_ack,
    output swap_err,
    output active_bank,
    output rd_data,
    output rd_valid
  );
endinterface

// File: rtl/coef_bank_dbuf.sv
// Double-buffered FIR coefficient store: the shadow bank is
// streamed in while the active bank serves reads, then swapped.
module coef_bank_dbuf #(
  parameter int COEF_W = 12,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  coef_bank_dbuf_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic              act;
  logic              done_q;
  logic              ack_q;
  logic              err_q;
  logic [COEF_W-1:0] rd_q;
  logic              rv_q;

  logic [COEF_W-1:0] mem [2][DEPTH];

  logic wr_en;
  logic last;
  logic in_rng;

  // load_start has priority over data, so a restart never writes
  assign wr_en = (state == LOAD)
               & ~bus.load_start
               & bus.load_valid;

  assign last   = (wptr == ADDR_W'(DEPTH - 1));
  assign in_rng = (32'(bus.rd_addr) < DEPTH);

  assign bus.load_ready  = (state == LOAD);
  assign bus.load_done   = done_q;
  assign bus.swap_ack    = ack_q;
  assign bus.swap_err    = err_q;
  assign bus.active_bank = act;
  assign bus.rd_data     = rd_q;
  assign bus.rd_valid    = rv_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      wptr   <= '0;
      act    <= 1'b0;
      done_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= bus.swap_req
              & (state != ARMED);
      unique case (state)
        IDLE: begin
          if (bus.load_start) begin
            state <= LOAD;
            wptr  <= '0;
          end
        end
        LOAD: begin
          if (bus.load_start) begin
            wptr <= '0;
          end else if (bus.load_valid) begin
            if (last) begin
              state  <= ARMED;
              wptr   <= '0;
              done_q <= 1'b1;
            end else begin
              wptr <= wptr + ADDR_W'(1);
            end
          end
        end
        ARMED: begin
          if (bus.swap_req) begin
            act   <= ~act;
            ack_q <= 1'b1;
            state <= IDLE;
          end else if (bus.load_start) begin
            state <= LOAD;
            wptr  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow is always the bank not being read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[0][i] <= '0;
        mem[1][i] <= '0;
      end
    end else if (wr_en) begin
      mem[~act][wptr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_q <= in_rng
              ? mem[act][bus.rd_addr]
              : '0;
      end
    end
  end

endmodule

// File: tb/tb_coef_bank_dbuf.sv
// Randomised and directed bench for coef_bank_dbuf, two
// instances (32x12 and 20x16) checked against a queue model.
module tb_coef_bank_dbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls = 1'b0;
  logic        lv = 1'b0;
  logic        sr = 1'b0;
  logic        re = 1'b0;
  logic [15:0] ld = '0;
  logic [4:0]  ra = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  coef_bank_dbuf_if #(.COEF_W(12), .ADDR_W(5)) if0 ();
  coef_bank_dbuf_if #(.COEF_W(16), .ADDR_W(5)) if1 ();

  assign if0.load_start = ls;
  assign if0.load_valid = lv;
  assign if0.load_data  = ld[11:0];
  assign if0.swap_req   = sr;
  assign if0.rd_en      = re;
  assign if0.rd_addr    = ra;

  assign if1.load_start = ls;
  assign if1.load_valid = lv;
  assign if1.load_data  = ld;
  assign if1.swap_req   = sr;
  assign if1.rd_en      = re;
  assign if1.rd_addr    = ra;

  coef_bank_dbuf #(.COEF_W(12), .DEPTH(32), .ADDR_W(5)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));

  coef_bank_dbuf #(.COEF_W(16), .DEPTH(20), .ADDR_W(5)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Model: the pending load is a queue; a swap makes it the
  // whole readable bank (a swap needs a full queue).
  localparam int DEP [2] = '{32, 20};
  localparam int WID [2] = '{12, 16};

  typedef enum int {M_IDLE, M_LOADING, M_ARMED} mode_t;

  mode_t mode [2];
  int    pend [2][$];
  int    bank [2][256];
  int    mact [2];
  int    mrd  [2];
  int    mrv  [2];
  int    mdone [2];
  int    mack [2];
  int    merr [2];
  bit    started = 1'b0;

  function automatic int sx(int v, int w);
    int m;
    m = v & ((1 << w) - 1);
    return (m >= (1 << (w - 1))) ? m - (1 << w) : m;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mode[k] = M_IDLE;
        pend[k].delete();
        for (int i = 0; i < 256; i++) bank[k][i] = 0;
        mact[k] = 0; mrd[k] = 0; mrv[k] = 0;
        mdone[k] = 0; mack[k] = 0; merr[k] = 0;
      end else begin
        mdone[k] = 0; mack[k] = 0; merr[k] = 0;
        mrv[k] = int'(re);
        if (re)
          mrd[k] = (int'(ra) < DEP[k]) ? bank[k][ra] : 0;
        if (sr && mode[k] != M_ARMED) merr[k] = 1;
        if (mode[k] == M_ARMED && sr) begin
          for (int i = 0; i < DEP[k]; i++)
            bank[k][i] = pend[k][i];
          pend[k].delete();
          mact[k] ^= 1;
          mack[k] = 1;
          mode[k] = M_IDLE;
        end else if (ls) begin
          pend[k].delete();
          mode[k] = M_LOADING;
        end else if (mode[k] == M_LOADING && lv) begin
          pend[k].push_back(sx(int'(ld), WID[k]));
          if (pend[k].size() == DEP[k]) begin
            mode[k] = M_ARMED;
            mdone[k] = 1;
          end
        end
      end
    end
    if (!rst_n) started = 1'b1;
  endtask

  task automatic chk(string nm, logic signed [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int k, logic rv, logic signed [31:0] rd,
                     logic lr, logic dn, logic ak, logic er,
                     logic ab);
    chk($sformatf("rd_valid%0d", k), rv, mrv[k]);
    chk($sformatf("rd_data%0d", k), rd, mrd[k]);
    chk($sformatf("load_ready%0d", k), lr,
        int'(mode[k] == M_LOADING));
    chk($sformatf("load_done%0d", k), dn, mdone[k]);
    chk($sformatf("swap_ack%0d", k), ak, mack[k]);
    chk($sformatf("swap_err%0d", k), er, merr[k]);
    chk($sformatf("active_bank%0d", k), ab, mact[k]);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      cmp(0, if0.rd_valid, $signed(if0.rd_data), if0.load_ready,
          if0.load_done, if0.swap_ack, if0.swap_err,
          if0.active_bank);
      cmp(1, if1.rd_valid, $signed(if1.rd_data), if1.load_ready,
          if1.load_done, if1.swap_ack, if1.swap_err,
          if1.active_bank);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int c;

    // reset then read everything back as zero
    do_reset();
    chk("rst_active_bank", if0.active_bank, 0);
    chk("rst_rd_valid", if0.rd_valid, 0);
    chk("rst_load_ready", if0.load_ready, 0);
    re = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i);
      step();
      chk("rst_rd", $signed(if0.rd_data), 0);
      chk("rst_rv", if0.rd_valid, 1);
    end
    re = 1'b0;

    // ramp load with a gap every third cycle, then swap
    ls = 1'b1; step(); ls = 1'b0;
    n = 0; c = 0;
    while (n < 32) begin
      lv = (c % 3 != 2);
      ld = 16'(-100 + n);
      step();
      if (lv) n++;
      c++;
    end
    lv = 1'b0;
    chk("ramp_done", if0.load_done, 1);
    sr = 1'b1; step(); sr = 1'b0;
    chk("ramp_swap_ack", if0.swap_ack, 1);
    chk("ramp_active", if0.active_bank, 1);
    re = 1'b1; ra = 5'd5; step(); re = 1'b0;
    chk("ramp_rd5", $signed(if0.rd_data), -95);
    chk("ramp_rd5_w16", $signed(if1.rd_data), -95);

    // reload shadow while continuously reading the active bank
    re = 1'b1; ra = 5'd10;
    ls = 1'b1; step(); ls = 1'b0;
    chk("dbuf_start_rd", $signed(if0.rd_data), -90);
    lv = 1'b1; ld = 16'h07FF;
    repeat (32) begin
      step();
      chk("dbuf_hold", $signed(if0.rd_data), -90);
    end
    lv = 1'b0;
    sr = 1'b1; step(); sr = 1'b0;
    chk("swap_cycle_rd", $signed(if0.rd_data), -90);
    chk("swap_cycle_ack", if0.swap_ack, 1);
    step();
    chk("post_swap_rd", $signed(if0.rd_data), 2047);
    chk("post_swap_rd_w16", $signed(if1.rd_data), 2047);
    re = 1'b0;

    // restart after 10 words, then abort a load with reset
    ls = 1'b1; step(); ls = 1'b0;
    lv = 1'b1; ld = 16'h0123;
    repeat (10) step();
    ls = 1'b1; step(); ls = 1'b0;
    repeat (31) begin
      step();
      chk("restart_early_done", if0.load_done, 0);
    end
    step();
    chk("restart_done", if0.load_done, 1);
    ls = 1'b1; step(); ls = 1'b0;
    repeat (5) step();
    lv = 1'b0;
    do_reset();
    chk("abort_ready0", if0.load_ready, 0);
    chk("abort_ready1", if1.load_ready, 0);
    chk("abort_active", if0.active_bank, 0);
    re = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i);
      step();
      chk("abort_rd", $signed(if0.rd_data), 0);
    end
    re = 1'b0;

    // protocol errors and swap winning over load_start
    sr = 1'b1; step(); sr = 1'b0;
    chk("idle_swap_err", if0.swap_err, 1);
    chk("idle_swap_bank", if0.active_bank, 0);
    ls = 1'b1; step(); ls = 1'b0;
    lv = 1'b1; ld = 16'h0055;
    repeat (32) step();
    lv = 1'b0;
    sr = 1'b1; ls = 1'b1; step(); sr = 1'b0; ls = 1'b0;
    chk("both_ack", if0.swap_ack, 1);
    chk("both_ready", if0.load_ready, 0);
    chk("both_bank", if0.active_bank, 1);
    step();
    chk("both_idle_ready", if0.load_ready, 0);

    // 20-deep instance: exact word count, range, sign
    do_reset();
    ls = 1'b1; step(); ls = 1'b0;
    for (int i = 0; i < 20; i++) begin
      lv = 1'b1;
      ld = (i == 3) ? 16'h8000 : 16'($urandom);
      step();
      if (i < 19) chk("sweep_early_done", if1.load_done, 0);
      else        chk("sweep_done20", if1.load_done, 1);
    end
    lv = 1'b0;
    sr = 1'b1; step(); sr = 1'b0;
    re = 1'b1; ra = 5'd25; step();
    chk("sweep_oor", $signed(if1.rd_data), 0);
    chk("sweep_oor_valid", if1.rd_valid, 1);
    ra = 5'd3; step();
    chk("sweep_neg", $signed(if1.rd_data), -32768);
    re = 1'b0;

    // random traffic against the model
    for (int t = 0; t < 3000; t++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      ls = ($urandom_range(0, 39) == 0);
      sr = !ls && ($urandom_range(0, 29) == 0);
      lv = ($urandom_range(0, 3) != 0);
      ld = 16'($urandom);
      re = $urandom_range(0, 1) != 0;
      ra = 5'($urandom_range(0, 31));
      step();
    end
    rst_n = 1'b1; ls = 1'b0; sr = 1'b0; lv = 1'b0; re = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
